// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - memory-stage request interface between pipeline and SRAM controller
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    // Pipeline side issues requests and consumes the result.
    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    // Controller side answers requests.
    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit pipeline load/store onto a 16-bit asynchronous SRAM
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] MEM_BASE    = 32'd1024
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    bus,
    output logic [17:0]         sram_addr,
    output logic [15:0]         sram_dq_out,
    input  logic [15:0]         sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_we_n,
    output logic                sram_oe_n,
    output logic                sram_ce_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] word_q, word_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req;
    logic        cnt_done;
    logic [16:0] word_in;

    assign req      = bus.wr_en | bus.rd_en;
    assign cnt_done = (cnt_q == CNT_LAST);

    // Word index of (address - MEM_BASE): only bits [18:2] matter, so subtract
    // the sliced fields and fold in the borrow out of the ignored byte bits.
    assign word_in = bus.address[18:2] - MEM_BASE[18:2]
                   - 17'(bus.address[1:0] < MEM_BASE[1:0]);

    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    assign bus.read_data = rdata_q;
    assign bus.ready     = ((state_q == IDLE) && !req) || (state_q == DONE);

    // Next-state: latch on request, time each half with the counter, capture read halves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        data_d  = data_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    word_d  = word_in;
                    data_d  = bus.write_data;
                    wr_d    = bus.wr_en;
                    cnt_d   = 4'd0;
                    state_d = LO;
                end
            end
            LO: begin
                if (cnt_done) begin
                    cnt_d   = 4'd0;
                    state_d = HI;
                    if (!wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (cnt_done) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                    if (!wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // State and latched request registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            word_q  <= 17'd0;
            data_q  <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM pin drive derived from the registered state only, so pins are quiet in IDLE/DONE.
    always_comb begin
        sram_addr   = 18'd0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        if (state_q == LO || state_q == HI) begin
            sram_addr = {word_q, (state_q == HI)};
            if (wr_q) begin
                sram_dq_out = (state_q == HI) ? data_q[31:16] : data_q[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The module SHALL have parameter WAIT_CYCLES, default 2, setting the number of SRAM cycles held per half-word access (legal range 1..15).
REQ-002 The module SHALL have parameter MEM_BASE, default 1024, giving the pipeline byte address that maps to SRAM half-word 0.
REQ-003 Port clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-low.
REQ-005 Port wr_en  input  1  pipeline store request.
REQ-006 Port rd_en  input  1  pipeline load request.
REQ-007 Port address  input  32  pipeline byte address; the ALU result.
REQ-008 Port write_data  input  32  store data; the Rm value.
REQ-009 Port read_data  output  32  load result.
REQ-010 Port ready  output  1  high = access complete or idle; low = pipeline must freeze.
REQ-011 Port sram_addr  output  18  SRAM half-word address.
REQ-012 Port sram_dq_out  output  16  write data driven to SRAM.
REQ-013 Port sram_dq_in  input  16  read data from SRAM.
REQ-014 Port sram_dq_oe  output  1  data-bus output enable; 1 = controller drives the bus.
REQ-015 Port sram_we_n  output  1  SRAM write strobe; active-low.
REQ-016 Port sram_oe_n  output  1  SRAM read strobe; active-low.
REQ-017 sram_ce_n, sram_ub_n and sram_lb_n SHALL be outputs of width 1 tied to 0.

Function
REQ-018 The block SHALL be the responder for the memory-stage request interface and SHALL implement states IDLE, LO, HI and DONE.
REQ-019 In IDLE with rd_en|wr_en=1, the block SHALL register address, write_data and op (write if wr_en=1, else read), SHALL drive ready=0 combinationally in that cycle, and SHALL go to LO.
REQ-020 In IDLE with no request, ready SHALL be 1 and the state SHALL stay IDLE.
REQ-021 If rd_en=1 and wr_en=1 together, the request SHALL be treated as a write.
REQ-022 LO and HI SHALL each last exactly WAIT_CYCLES cycles, counted by an internal counter that is cleared on each state entry.
REQ-023 Sequencing SHALL be LO -> HI -> DONE, and DONE SHALL last one cycle before returning to IDLE.
REQ-024 ready SHALL be 0 in LO and HI, and 1 in DONE.
REQ-025 Total latency from request cycle to the ready=1 cycle, inclusive, SHALL be 2*WAIT_CYCLES+2 (6 at the default).
REQ-026 Requests present during DONE SHALL be ignored; a request still asserted in the following IDLE cycle SHALL start a new access.
REQ-027 Address mapping: a = latched_address - MEM_BASE, taken modulo 2^32.
REQ-028 sram_addr SHALL be {a[18:2], 1'b0} in LO and {a[18:2], 1'b1} in HI.
REQ-029 Address bits [1:0] and bits above 18 SHALL be ignored.
REQ-030 Write, LO: sram_dq_out = data[15:0], sram_dq_oe=1, sram_we_n=0.
REQ-031 Write, HI: sram_dq_out = data[31:16], sram_dq_oe=1, sram_we_n=0.
REQ-032 During a write, sram_oe_n SHALL be 1.
REQ-033 Read, LO and HI: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
REQ-034 In a read, sram_dq_in SHALL be captured into read_data[15:0] on the last LO cycle and into read_data[31:16] on the last HI cycle.
REQ-035 read_data SHALL be stable and valid in DONE, and SHALL hold until the next read overwrites it.
REQ-036 A write SHALL NOT change read_data.
REQ-037 In IDLE and DONE: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
REQ-038 Input changes after the request is latched SHALL NOT affect an access in progress.

Reset
REQ-039 rst=0 SHALL asynchronously force state=IDLE, counter=0, read_data=0, latched registers=0, ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0 and sram_dq_out=0.
REQ-040 Reset mid-access SHALL abort the access with no further SRAM strobes, and no partial read SHALL appear on read_data.
REQ-041 After rst deasserts, the first rising edge SHALL sample IDLE behaviour.

Verification
REQ-042 Write with defaults: wr_en=1, address=1024, write_data=0xDEADBEEF for 6 cycles.
- Required response: ready=0 for cycles 0-4 and 1 at cycle 5.
- Cycles 1-2: sram_addr=0, dq_out=0xBEEF, we_n=0.
- Cycles 3-4: sram_addr=1, dq_out=0xDEAD, we_n=0.
REQ-043 Read back: rd_en=1, address=1024, SRAM model returning the stored data.
- Required response: read_data=0xDEADBEEF at the ready=1 cycle (cycle 5), with oe_n=0 in cycles 1-4 and dq_oe=0 throughout.
REQ-044 Address map: rd_en=1, address=1036.
- Required response: sram_addr=6 in LO and 7 in HI.
REQ-045 Simultaneous and back-to-back:
- rd_en=wr_en=1 SHALL perform a write (we_n=0, read_data unchanged).
- A request held across DONE SHALL cause a second access starting at the next IDLE cycle.
- Total SHALL be 12 cycles for two accesses.
REQ-046 Reset mid-op: assert rst=0 during HI of a read.
- Required response: ready=1, oe_n=1 and state IDLE immediately, without a clock edge.
- read_data SHALL keep its reset value 0.
REQ-047 Parameter: WAIT_CYCLES=1.
- Required response: latency is 4 cycles, and LO and HI last one cycle each.
